// File: rtl/d_drain_arbiter.sv
// ---------------------------------------------------------------------------
// d_drain_arbiter
//
// Read-side arbiter for the D0/D1 destination FIFOs. It pops both FIFOs,
// merges their words round-robin into one output stream, and absorbs the
// one-cycle FIFO read latency with a 2-entry output buffer. Downstream
// backpressure comes in through out_ready. Per-source counters track the
// words accepted downstream.
//
// Ports
//   clk, reset          : single clock, asynchronous active-high reset
//   data_out_D0/D1      : FIFO read data, valid the cycle after Dx_pop
//   empty_fifo_D0/D1    : FIFO empty flags (used in the current cycle)
//   enable              : permits new pops (in-flight reads still complete)
//   out_ready           : downstream accepts data_out this cycle
//   D0_pop, D1_pop      : FIFO read strobes, at most one per cycle
//   data_out, out_src   : head word of the output buffer and its source
//   valid_out           : data_out holds a word
//   cnt_D0, cnt_D1      : words accepted downstream per source (wrapping)
//   dbg_occ             : output buffer occupancy (0..2), for observation
//
// Output handshake: a word transfers on every rising edge where
// valid_out & out_ready are both high. While valid_out is high and
// out_ready is low, data_out and out_src are held stable. valid_out never
// depends combinationally on out_ready.
// ---------------------------------------------------------------------------
module d_drain_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_out_D0,
    input  logic [DATA_WIDTH-1:0] data_out_D1,
    input  logic                  empty_fifo_D0,
    input  logic                  empty_fifo_D1,
    input  logic                  enable,
    input  logic                  out_ready,
    output logic                  D0_pop,
    output logic                  D1_pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  out_src,
    output logic [CNT_WIDTH-1:0]  cnt_D0,
    output logic [CNT_WIDTH-1:0]  cnt_D1,
    output logic [1:0]            dbg_occ
);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [1:0]            occ;        // buffer occupancy, 0..2
    logic                  pend;       // a pop was issued last cycle
    logic                  pend_src;   // source of that pop
    logic                  last;       // source granted most recently

    logic [DATA_WIDTH-1:0] head_data;  // buffer entry 0 (output side)
    logic                  head_src;
    logic [DATA_WIDTH-1:0] tail_data;  // buffer entry 1
    logic                  tail_src;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic                  deq;
    logic [2:0]            fill;
    logic                  room;
    logic                  grant_valid;
    logic                  grant_src;
    logic [DATA_WIDTH-1:0] cap_data;

    logic [1:0]            occ_nxt;
    logic [DATA_WIDTH-1:0] head_data_nxt;
    logic                  head_src_nxt;
    logic [DATA_WIDTH-1:0] tail_data_nxt;
    logic                  tail_src_nxt;

    assign valid_out = (occ != 2'd0);
    assign data_out  = head_data;
    assign out_src   = head_src;
    assign dbg_occ   = occ;

    assign deq = valid_out & out_ready;

    // Words already committed to the buffer after this edge: those stored,
    // plus the one arriving from last cycle's pop, minus the one leaving now.
    // A new pop is allowed only if that leaves a free slot for its data next
    // cycle. Using out_ready here is what sustains one word per cycle.
    assign fill = {1'b0, occ} + {2'b00, pend} - {2'b00, deq};
    assign room = (fill <= 3'd1);

    // Round-robin grant on the current empty flags.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = 1'b0;
        if (enable && room) begin
            if (!empty_fifo_D0 && !empty_fifo_D1) begin
                grant_valid = 1'b1;
                grant_src   = ~last;
            end else if (!empty_fifo_D0) begin
                grant_valid = 1'b1;
                grant_src   = 1'b0;
            end else if (!empty_fifo_D1) begin
                grant_valid = 1'b1;
                grant_src   = 1'b1;
            end
        end
    end

    // Strobes are masked while reset is high so the FIFOs never see a read
    // during reset, even though the grant logic itself is unaware of it.
    assign D0_pop = grant_valid & ~grant_src & ~reset;
    assign D1_pop = grant_valid &  grant_src & ~reset;

    // Data returned for last cycle's pop.
    assign cap_data = pend_src ? data_out_D1 : data_out_D0;

    // Buffer update: capture writes the tail slot after any shift caused
    // by a dequeue, so the relative order of words is always preserved.
    always_comb begin
        occ_nxt       = occ;
        head_data_nxt = head_data;
        head_src_nxt  = head_src;
        tail_data_nxt = tail_data;
        tail_src_nxt  = tail_src;
        case ({pend, deq})
            2'b10: begin
                occ_nxt = occ + 2'd1;
                if (occ == 2'd0) begin
                    head_data_nxt = cap_data;
                    head_src_nxt  = pend_src;
                end else begin
                    tail_data_nxt = cap_data;
                    tail_src_nxt  = pend_src;
                end
            end
            2'b01: begin
                occ_nxt       = occ - 2'd1;
                head_data_nxt = tail_data;
                head_src_nxt  = tail_src;
            end
            2'b11: begin
                // Shift and write: occupancy is unchanged.
                if (occ == 2'd1) begin
                    head_data_nxt = cap_data;
                    head_src_nxt  = pend_src;
                end else begin
                    head_data_nxt = tail_data;
                    head_src_nxt  = tail_src;
                    tail_data_nxt = cap_data;
                    tail_src_nxt  = pend_src;
                end
            end
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ       <= 2'd0;
            pend      <= 1'b0;
            pend_src  <= 1'b0;
            last      <= 1'b1;   // D0 wins the first tie
            head_data <= '0;
            head_src  <= 1'b0;
            tail_data <= '0;
            tail_src  <= 1'b0;
        end else begin
            occ       <= occ_nxt;
            pend      <= grant_valid;
            pend_src  <= grant_src;
            if (grant_valid) begin
                last <= grant_src;
            end
            head_data <= head_data_nxt;
            head_src  <= head_src_nxt;
            tail_data <= tail_data_nxt;
            tail_src  <= tail_src_nxt;
        end
    end

    // Accepted-word counters, wrapping naturally at 2^CNT_WIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_D0 <= '0;
            cnt_D1 <= '0;
        end else if (deq) begin
            if (head_src) begin
                cnt_D1 <= cnt_D1 + 1'b1;
            end else begin
                cnt_D0 <= cnt_D0 + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_d_drain_arbiter.sv
// ---------------------------------------------------------------------------
// tb_d_drain_arbiter
//
// Bench for d_drain_arbiter. Two behavioural FIFOs with one-cycle read
// latency feed the DUT. A reference model tracks every word popped (in pop
// order, with the cycle it was popped) and derives from that the expected
// grants, buffer occupancy, head word and counters each cycle.
// ---------------------------------------------------------------------------
module tb_d_drain_arbiter;

    localparam int DW    = 6;
    localparam int CW    = 8;
    localparam int DEPTH = 4096;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_out_D0;
    logic [DW-1:0] data_out_D1;
    logic          empty_fifo_D0;
    logic          empty_fifo_D1;
    logic          enable = 1'b0;
    logic          out_ready = 1'b0;
    logic          D0_pop;
    logic          D1_pop;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          out_src;
    logic [CW-1:0] cnt_D0;
    logic [CW-1:0] cnt_D1;
    logic [1:0]    dbg_occ;

    d_drain_arbiter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .data_out_D0   (data_out_D0),
        .data_out_D1   (data_out_D1),
        .empty_fifo_D0 (empty_fifo_D0),
        .empty_fifo_D1 (empty_fifo_D1),
        .enable        (enable),
        .out_ready     (out_ready),
        .D0_pop        (D0_pop),
        .D1_pop        (D1_pop),
        .data_out      (data_out),
        .valid_out     (valid_out),
        .out_src       (out_src),
        .cnt_D0        (cnt_D0),
        .cnt_D1        (cnt_D1),
        .dbg_occ       (dbg_occ)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- behavioural FIFOs ----------------
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    int wp0 = 0, wp1 = 0;   // written by the stimulus process only
    int rp0 = 0, rp1 = 0;   // written by the FIFO process only

    assign empty_fifo_D0 = (wp0 == rp0);
    assign empty_fifo_D1 = (wp1 == rp1);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            rp0 <= wp0;
            rp1 <= wp1;
            data_out_D0 <= '0;
            data_out_D1 <= '0;
        end else begin
            if (D0_pop && (rp0 != wp0)) begin
                data_out_D0 <= mem0[rp0 % DEPTH];
                rp0 <= rp0 + 1;
            end
            if (D1_pop && (rp1 != wp1)) begin
                data_out_D1 <= mem1[rp1 % DEPTH];
                rp1 <= rp1 + 1;
            end
        end
    end

    // ---------------- scoreboard / model state ----------------
    logic [DW:0]  exp_q[$];     // {src, data} in pop order
    int           exp_cyc[$];   // cycle each queued word was popped
    logic [DW:0]  acc_q[$];     // words observed accepted downstream
    logic         m_last = 1'b1;
    int           m_cnt0 = 0, m_cnt1 = 0;
    int           cyc = 0;
    int           checks = 0, errors = 0;

    typedef struct {
        logic          en;
        logic          rdy;
        logic          p0;
        logic          p1;
        logic          v;
        logic [DW-1:0] data;
        logic          src;
    } vec_t;
    vec_t rr_vec[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic push0(input logic [DW-1:0] d);
        mem0[wp0 % DEPTH] = d;
        wp0++;
    endtask

    task automatic push1(input logic [DW-1:0] d);
        mem1[wp1 % DEPTH] = d;
        wp1++;
    endtask

    // Apply inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic en, input logic rdy);
        enable = en;
        out_ready = rdy;
        #1;
    endtask

    // Compare the DUT against the model for this cycle, advance the model,
    // then move to just after the next rising edge.
    task automatic model_check();
        int          occ_m;
        int          outst;
        logic        m_valid, m_deq, m_room, a0, a1, g_v, g_s;
        logic [DW:0] head;
        occ_m = 0;
        foreach (exp_cyc[i]) if (exp_cyc[i] <= cyc - 2) occ_m++;
        m_valid = (occ_m != 0);
        m_deq   = m_valid && out_ready;
        outst   = exp_q.size() - (m_deq ? 1 : 0);
        m_room  = (outst <= 1);
        a0 = (wp0 != rp0);
        a1 = (wp1 != rp1);
        g_v = 1'b0;
        g_s = 1'b0;
        if (enable && m_room) begin
            if (a0 && a1) begin g_v = 1'b1; g_s = ~m_last; end
            else if (a0)  begin g_v = 1'b1; g_s = 1'b0; end
            else if (a1)  begin g_v = 1'b1; g_s = 1'b1; end
        end
        chk("d0_pop", 32'(D0_pop), 32'(g_v & ~g_s));
        chk("d1_pop", 32'(D1_pop), 32'(g_v & g_s));
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        if (m_valid) begin
            head = exp_q[0];
            chk("data_out", 32'(data_out), 32'(head[DW-1:0]));
            chk("out_src", 32'(out_src), 32'(head[DW]));
        end
        chk("cnt_d0", 32'(cnt_D0), 32'(m_cnt0 % 256));
        chk("cnt_d1", 32'(cnt_D1), 32'(m_cnt1 % 256));
        chk("occ", 32'(dbg_occ), 32'(occ_m));
        chk("occ_le2", 32'(dbg_occ > 2'd2), 32'd0);
        if (valid_out && out_ready) acc_q.push_back({out_src, data_out});
        if (m_deq) begin
            head = exp_q.pop_front();
            void'(exp_cyc.pop_front());
            if (head[DW]) m_cnt1++; else m_cnt0++;
        end
        if (g_v) begin
            exp_q.push_back({g_s, (g_s ? mem1[rp1 % DEPTH] : mem0[rp0 % DEPTH])});
            exp_cyc.push_back(cyc);
            m_last = g_s;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Assert reset mid-cycle, check the immediate reset values, release it
    // after one rising edge and restart the model.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_d0_pop", 32'(D0_pop), 32'd0);
        chk("rst_d1_pop", 32'(D1_pop), 32'd0);
        chk("rst_cnt_d0", 32'(cnt_D0), 32'd0);
        chk("rst_cnt_d1", 32'(cnt_D1), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_src", 32'(out_src), 32'd0);
        chk("rst_occ", 32'(dbg_occ), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        exp_cyc.delete();
        m_last = 1'b1;
        m_cnt0 = 0;
        m_cnt1 = 0;
        cyc = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int          peak;
        int          stall_pops;
        logic [DW-1:0] held;
        logic [DW:0] exp_w;
        int          n;

        // Round-robin vectors: D0 holds 10..13, D1 holds 20..23.
        //                en    rdy   p0    p1    v     data   src
        rr_vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'h00, 1'b0};
        rr_vec[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'h00, 1'b0};
        rr_vec[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h10, 1'b0};
        rr_vec[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h20, 1'b1};
        rr_vec[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h11, 1'b0};
        rr_vec[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h21, 1'b1};
        rr_vec[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'h12, 1'b0};
        rr_vec[7]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 6'h22, 1'b1};
        rr_vec[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'h13, 1'b0};
        rr_vec[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 6'h23, 1'b1};
        rr_vec[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'h00, 1'b0};

        // ---- power-on reset: pops stay low even with data and enable ----
        repeat (2) @(posedge clk);
        #1;
        push0(6'h2a);
        enable = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("por_d0_pop", 32'(D0_pop), 32'd0);
        chk("por_valid", 32'(valid_out), 32'd0);
        chk("por_cnt_d0", 32'(cnt_D0), 32'd0);
        chk("por_data", 32'(data_out), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        enable = 1'b0;

        // ---- single source: D0 05,06,07 ----
        push0(6'h05); push0(6'h06); push0(6'h07);
        drive(1'b1, 1'b1);
        chk("ss_pop0", 32'(D0_pop), 32'd1);
        chk("ss_valid0", 32'(valid_out), 32'd0);
        model_check();
        drive(1'b1, 1'b1);
        chk("ss_pop1", 32'(D0_pop), 32'd1);
        model_check();
        drive(1'b1, 1'b1);
        chk("ss_w0", 32'({valid_out, out_src, data_out}), 32'({1'b1, 1'b0, 6'h05}));
        model_check();
        drive(1'b1, 1'b1);
        chk("ss_w1", 32'({valid_out, out_src, data_out}), 32'({1'b1, 1'b0, 6'h06}));
        model_check();
        drive(1'b1, 1'b1);
        chk("ss_w2", 32'({valid_out, out_src, data_out}), 32'({1'b1, 1'b0, 6'h07}));
        model_check();
        drive(1'b1, 1'b1);
        chk("ss_done_valid", 32'(valid_out), 32'd0);
        chk("ss_cnt_d0", 32'(cnt_D0), 32'd3);
        model_check();

        // ---- round robin, table driven ----
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push0(6'(6'h10 + k));
            push1(6'(6'h20 + k));
        end
        for (int i = 0; i < 11; i++) begin
            drive(rr_vec[i].en, rr_vec[i].rdy);
            chk($sformatf("rr%0d_d0_pop", i), 32'(D0_pop), 32'(rr_vec[i].p0));
            chk($sformatf("rr%0d_d1_pop", i), 32'(D1_pop), 32'(rr_vec[i].p1));
            chk($sformatf("rr%0d_valid", i), 32'(valid_out), 32'(rr_vec[i].v));
            if (rr_vec[i].v) begin
                chk($sformatf("rr%0d_data", i), 32'(data_out), 32'(rr_vec[i].data));
                chk($sformatf("rr%0d_src", i), 32'(out_src), 32'(rr_vec[i].src));
            end
            model_check();
        end
        chk("rr_cnt_d0", 32'(cnt_D0), 32'd4);
        chk("rr_cnt_d1", 32'(cnt_D1), 32'd4);

        // ---- backpressure: out_ready low for 5 cycles mid-stream ----
        acc_q.delete();
        for (int k = 0; k < 8; k++) begin
            push0(6'(6'h28 + k));
            push1(6'(6'h30 + k));
        end
        peak = 0;
        stall_pops = 0;
        held = '0;
        for (int c = 0; c < 30; c++) begin
            drive(1'b1, !(c >= 4 && c < 9));
            if (c >= 4 && c < 9) begin
                if (int'(dbg_occ) > peak) peak = int'(dbg_occ);
                if (c == 4) held = data_out;
                else chk("bp_hold", 32'(data_out), 32'(held));
                stall_pops += int'(D0_pop) + int'(D1_pop);
            end
            model_check();
        end
        chk("bp_peak_occ", 32'(peak), 32'd2);
        chk("bp_stall_pops_le1", 32'(stall_pops > 1), 32'd0);
        chk("bp_count", 32'(acc_q.size()), 32'd16);
        for (int k = 0; k < 16; k++) begin
            if (k < acc_q.size()) begin
                exp_w = (k % 2 == 0) ? {1'b0, 6'(6'h28 + k / 2)} : {1'b1, 6'(6'h30 + k / 2)};
                chk($sformatf("bp_order%0d", k), 32'(acc_q[k]), 32'(exp_w));
            end
        end

        // ---- enable gating: drop enable one cycle after a pop ----
        push0(6'h38); push0(6'h39); push0(6'h3a);
        drive(1'b1, 1'b1);
        chk("en_first_pop", 32'(D0_pop), 32'd1);
        model_check();
        for (int c = 1; c < 6; c++) begin
            drive(1'b0, 1'b1);
            chk("en_off_pop", 32'({D0_pop, D1_pop}), 32'd0);
            if (c == 2) chk("en_word", 32'({valid_out, data_out}), 32'({1'b1, 6'h38}));
            model_check();
        end
        drive(1'b1, 1'b1);
        chk("en_resume_pop", 32'(D0_pop), 32'd1);
        model_check();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b1);
            model_check();
        end

        // ---- reset mid-stream with a full buffer ----
        for (int k = 1; k <= 6; k++) push0(6'(k));
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b0);
            model_check();
        end
        drive(1'b1, 1'b0);
        chk("mr_occ_full", 32'(dbg_occ), 32'd2);
        chk("mr_valid", 32'(valid_out), 32'd1);
        do_reset();
        push0(6'h11);
        push1(6'h21);
        drive(1'b1, 1'b1);
        chk("mr_tie_d0", 32'(D0_pop), 32'd1);
        chk("mr_tie_not_d1", 32'(D1_pop), 32'd0);
        model_check();
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b1);
            model_check();
        end

        // ---- counter wrap: 256 words from D1 ----
        do_reset();
        for (int k = 0; k < 256; k++) push1(6'($urandom_range(0, 63)));
        for (int c = 0; c < 262; c++) begin
            drive(1'b1, 1'b1);
            model_check();
        end
        chk("wrap_cnt_d1", 32'(cnt_D1), 32'd0);
        chk("wrap_cnt_d0", 32'(cnt_D0), 32'd0);
        chk("wrap_total", 32'(m_cnt1), 32'd256);

        // ---- randomized traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 3 && (wp0 - rp0) < 64) push0(6'($urandom_range(0, 63)));
            if ($urandom_range(0, 9) < 3 && (wp1 - rp1) < 64) push1(6'($urandom_range(0, 63)));
            drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0);
            model_check();
        end

        // ---- bounded drain ----
        n = 0;
        while (!((wp0 == rp0) && (wp1 == rp1) && (exp_q.size() == 0)) && n < 400) begin
            drive(1'b1, 1'b1);
            model_check();
            n++;
        end
        chk("drain_left", 32'(exp_q.size() + (wp0 - rp0) + (wp1 - rp1)), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
